spi_cmd_ctrl: RTL and testbench

SPI_CMD_CTRL -- requirements
Module: spi_cmd_ctrl

---
 rtl/spi_pkg.sv | 8 +
 rtl/spi_byte_fifo.sv | 43 ++++
 rtl/spi_cmd_ctrl.sv | 116 +++++++++++
 tb/tb_spi_cmd_ctrl.sv | 231 +++++++++++++++++++++++
 4 files changed

// File: rtl/spi_pkg.sv
// Shared types and constants for the SPI command controller.
package spi_pkg;
  localparam int         DEF_FIFO_DEPTH = 16;
  localparam logic [7:0] OP_WRITE       = 8'h3C;
  localparam logic [7:0] OP_READ        = 8'h5B;

  typedef enum logic [2:0] {ST_IDLE, ST_CHECK, ST_START, ST_BUSY, ST_DONE} state_t;
endpackage

// File: rtl/spi_byte_fifo.sv
// Synchronous show-ahead byte FIFO with occupancy count.
module spi_byte_fifo #(
  parameter int DEPTH = 16,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        push,
  input  logic [7:0]  din,
  input  logic        pop,
  output logic [7:0]  dout,
  output logic        full,
  output logic        empty,
  output logic [AW:0] count
);
  logic [7:0]    mem [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic          do_push, do_pop;

  assign empty   = (count == '0);
  assign full    = (count == (AW+1)'(DEPTH));
  assign do_pop  = pop & ~empty;
  // a push into a full FIFO is fine when the head leaves in the same cycle
  assign do_push = push & (~full | do_pop);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      count <= count + (AW+1)'(do_push) - (AW+1)'(do_pop);
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= din;
  end

  assign dout = empty ? 8'h00 : mem[rd_ptr];
endmodule

// File: rtl/spi_cmd_ctrl.sv
// Host command front-end for an SPI master: validates commands, feeds
// address/payload bytes on request and collects read data.
module spi_cmd_ctrl
  import spi_pkg::*;
#(
  parameter int FIFO_DEPTH = DEF_FIFO_DEPTH
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       cmd_valid,
  output logic       cmd_ready,
  input  logic       cmd_wr,
  input  logic [7:0] cmd_len,
  input  logic [7:0] cmd_addr,
  input  logic       tx_valid,
  output logic       tx_ready,
  input  logic [7:0] tx_data,
  output logic       rx_valid,
  input  logic       rx_ready,
  output logic [7:0] rx_data,
  output logic       busy,
  output logic       done,
  output logic       err,
  output logic       start_trig,
  output logic       wr,
  output logic [7:0] len,
  input  logic       wdat_req,
  output logic [7:0] wdat,
  input  logic       rdat_vld,
  input  logic [7:0] rdat,
  input  logic       trans_over
);
  localparam int AW = $clog2(FIFO_DEPTH);

  state_t      state, state_n;
  logic        lat_wr, first_req, sticky_uf, reject, feed;
  logic [7:0]  lat_len, lat_addr, tx_dout;
  logic        tx_full, tx_empty, tx_pop, rx_full, rx_empty, rx_push;
  logic [AW:0] tx_cnt, rx_cnt;

  spi_byte_fifo #(.DEPTH(FIFO_DEPTH)) u_tx (
    .clk(clk), .rst(rst), .push(tx_valid & tx_ready), .din(tx_data), .pop(tx_pop),
    .dout(tx_dout), .full(tx_full), .empty(tx_empty), .count(tx_cnt)
  );

  spi_byte_fifo #(.DEPTH(FIFO_DEPTH)) u_rx (
    .clk(clk), .rst(rst), .push(rx_push), .din(rdat), .pop(rx_valid & rx_ready),
    .dout(rx_data), .full(rx_full), .empty(rx_empty), .count(rx_cnt)
  );

  assign tx_ready = ~tx_full;
  assign rx_valid = ~rx_empty;
  assign rx_push  = rdat_vld & (state == ST_BUSY) & ~lat_wr & ~rx_full;
  assign feed     = wdat_req & (state == ST_BUSY);
  assign tx_pop   = feed & ~first_req & lat_wr & ~tx_empty;
  assign wr       = lat_wr;
  assign len      = lat_len;

  // the whole payload must already be buffered (write) or have room (read)
  assign reject = (lat_len == 8'd0) || (int'(lat_len) > FIFO_DEPTH) ||
                  ( lat_wr && int'(tx_cnt) < int'(lat_len)) ||
                  (!lat_wr && (FIFO_DEPTH - int'(rx_cnt)) < int'(lat_len));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= ST_IDLE;
    else     state <= state_n;
  end

  always_comb begin
    state_n = state;
    case (state)
      ST_IDLE:  if (cmd_valid) state_n = ST_CHECK;
      ST_CHECK: state_n = reject ? ST_IDLE : ST_START;
      ST_START: state_n = ST_BUSY;
      ST_BUSY:  if (trans_over) state_n = ST_DONE;
      ST_DONE:  state_n = ST_IDLE;
      default:  state_n = ST_IDLE;
    endcase
  end

  always_comb begin
    cmd_ready  = (state == ST_IDLE);
    busy       = (state != ST_IDLE);
    start_trig = (state == ST_START);
    done       = (state == ST_DONE);
    err        = ((state == ST_CHECK) && reject) || ((state == ST_DONE) && sticky_uf);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      lat_wr    <= 1'b0;
      lat_len   <= 8'h00;
      lat_addr  <= 8'h00;
      first_req <= 1'b0;
      sticky_uf <= 1'b0;
      wdat      <= 8'hFF;
    end else begin
      if (state == ST_IDLE && cmd_valid) begin
        lat_wr   <= cmd_wr;
        lat_len  <= cmd_len;
        lat_addr <= cmd_addr;
      end
      if (state == ST_START) first_req <= 1'b1;
      if (feed) begin
        first_req <= 1'b0;
        if (first_req)   wdat <= lat_addr;
        else if (tx_pop) wdat <= tx_dout;
        else begin
          wdat      <= 8'hFF;
          sticky_uf <= 1'b1;
        end
      end
      if (state == ST_DONE) sticky_uf <= 1'b0;
    end
  end
endmodule

// File: tb/tb_spi_cmd_ctrl.sv
// Self-checking bench: table of commands with a bench-side SPI master and
// byte scoreboards, plus reset and back-pressure sequences.
module tb_spi_cmd_ctrl;
  logic       clk = 1'b0, rst;
  logic       cmd_valid, cmd_ready, cmd_wr;
  logic [7:0] cmd_len, cmd_addr;
  logic       tx_valid, tx_ready, rx_valid, rx_ready;
  logic [7:0] tx_data, rx_data;
  logic       busy, done, err, start_trig, wr;
  logic [7:0] len, wdat, rdat;
  logic       wdat_req, rdat_vld, trans_over;

  int n_tests = 0, n_fail = 0;
  int n_start = 0, n_done = 0, n_done_err = 0;
  logic [7:0] tx_model[$];
  logic [7:0] rx_exp[$];

  typedef struct {
    string      name;
    logic       wr;
    int         len;
    logic [7:0] addr;
    int         npre;
    logic [7:0] pre_base, pre_step;
    int         nrd;
    logic [7:0] rd_base, rd_step;
    int         extra;
    logic       rej;
    logic       uf;
  } cmd_t;

  cmd_t tbl[7];

  spi_cmd_ctrl #(.FIFO_DEPTH(16)) dut (
    .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_wr(cmd_wr), .cmd_len(cmd_len), .cmd_addr(cmd_addr),
    .tx_valid(tx_valid), .tx_ready(tx_ready), .tx_data(tx_data),
    .rx_valid(rx_valid), .rx_ready(rx_ready), .rx_data(rx_data),
    .busy(busy), .done(done), .err(err), .start_trig(start_trig),
    .wr(wr), .len(len), .wdat_req(wdat_req), .wdat(wdat),
    .rdat_vld(rdat_vld), .rdat(rdat), .trans_over(trans_over)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (start_trig)  n_start++;
    if (done)        n_done++;
    if (done && err) n_done_err++;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  function automatic cmd_t mk(input string name, input logic w, input int l, input logic [7:0] a,
                              input int np, input logic [7:0] pb, input logic [7:0] ps,
                              input int nr, input logic [7:0] rb, input logic [7:0] rs,
                              input int ex, input logic rj, input logic u);
    cmd_t c;
    c.name = name; c.wr = w; c.len = l; c.addr = a;
    c.npre = np; c.pre_base = pb; c.pre_step = ps;
    c.nrd = nr; c.rd_base = rb; c.rd_step = rs;
    c.extra = ex; c.rej = rj; c.uf = u;
    return c;
  endfunction

  task automatic push_tx(input logic [7:0] b);
    check("tx_ready_before_push", tx_ready, 1);
    tx_valid = 1'b1; tx_data = b;
    tx_model.push_back(b);
    tick();
    tx_valid = 1'b0;
  endtask

  task automatic drain_rx(input int n);
    rx_ready = 1'b1;
    for (int i = 0; i < n; i++) begin
      check("rx_valid_drain", rx_valid, 1);
      check("rx_data_order", rx_data, rx_exp.pop_front());
      tick();
    end
    rx_ready = 1'b0;
    check("rx_empty_after_drain", rx_valid, 0);
  endtask

  task automatic do_cmd(input cmd_t c);
    int s0, d0, de0, nreq;
    logic [7:0] b, exp;
    s0 = n_start; d0 = n_done; de0 = n_done_err;
    for (int i = 0; i < c.npre; i++) begin
      b = c.pre_base + 8'(i) * c.pre_step;
      push_tx(b);
    end
    check({c.name, "_cmd_ready"}, cmd_ready, 1);
    cmd_valid = 1'b1; cmd_wr = c.wr; cmd_len = 8'(c.len); cmd_addr = c.addr;
    tick();
    cmd_valid = 1'b0;
    check({c.name, "_busy_check"}, busy, 1);
    check({c.name, "_check_err"}, err, c.rej);
    tick();
    if (c.rej) begin
      check({c.name, "_no_start"}, start_trig, 0);
      check({c.name, "_back_idle"}, cmd_ready, 1);
      tick();
      check({c.name, "_start_count"}, n_start - s0, 0);
      check({c.name, "_done_count"}, n_done - d0, 0);
      return;
    end
    check({c.name, "_start_trig"}, start_trig, 1);
    check({c.name, "_wr"}, wr, c.wr);
    check({c.name, "_len"}, len, c.len);
    tick();
    check({c.name, "_start_one_cycle"}, start_trig, 0);
    nreq = (c.wr ? c.len + 1 : 1) + c.extra;
    for (int r = 0; r < nreq; r++) begin
      wdat_req = 1'b1;
      tick();
      wdat_req = 1'b0;
      if (r == 0)                            exp = c.addr;
      else if (c.wr && tx_model.size() != 0) exp = tx_model.pop_front();
      else                                   exp = 8'hFF;
      check({c.name, "_wdat"}, wdat, exp);
      tick();
      check({c.name, "_wdat_hold"}, wdat, exp);
    end
    for (int i = 0; i < c.nrd; i++) begin
      b = c.rd_base + 8'(i) * c.rd_step;
      rdat_vld = 1'b1; rdat = b;
      rx_exp.push_back(b);
      tick();
      rdat_vld = 1'b0;
    end
    check({c.name, "_wr_stable"}, wr, c.wr);
    check({c.name, "_len_stable"}, len, c.len);
    trans_over = 1'b1;
    tick();
    trans_over = 1'b0;
    check({c.name, "_done"}, done, 1);
    check({c.name, "_done_err"}, err, c.uf);
    tick();
    check({c.name, "_done_pulse"}, done, 0);
    check({c.name, "_idle_ready"}, cmd_ready, 1);
    check({c.name, "_start_count"}, n_start - s0, 1);
    check({c.name, "_done_count"}, n_done - d0, 1);
    check({c.name, "_done_err_count"}, n_done_err - de0, int'(c.uf));
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_cmd_ready"}, cmd_ready, 1);
    check({tag, "_busy"}, busy, 0);
    check({tag, "_done"}, done, 0);
    check({tag, "_err"}, err, 0);
    check({tag, "_start_trig"}, start_trig, 0);
    check({tag, "_wr"}, wr, 0);
    check({tag, "_len"}, len, 0);
    check({tag, "_wdat"}, wdat, 8'hFF);
    check({tag, "_tx_ready"}, tx_ready, 1);
    check({tag, "_rx_valid"}, rx_valid, 0);
    check({tag, "_rx_data"}, rx_data, 0);
  endtask

  initial begin
    tbl[0] = mk("wr3",      1,  3, 8'hA5, 3, 8'h11, 8'h11, 0, 8'h00, 8'h00, 0, 0, 0);
    tbl[1] = mk("rd2",      0,  2, 8'h40, 0, 8'h00, 8'h00, 2, 8'h5A, 8'h69, 0, 0, 0);
    tbl[2] = mk("len0",     0,  0, 8'h01, 0, 8'h00, 8'h00, 0, 8'h00, 8'h00, 0, 1, 0);
    tbl[3] = mk("len17",    1, 17, 8'h02, 0, 8'h00, 8'h00, 0, 8'h00, 8'h00, 0, 1, 0);
    tbl[4] = mk("wr_short", 1,  4, 8'h10, 2, 8'h44, 8'h11, 0, 8'h00, 8'h00, 0, 1, 0);
    tbl[5] = mk("wr2",      1,  2, 8'h20, 0, 8'h00, 8'h00, 0, 8'h00, 8'h00, 0, 0, 0);
    tbl[6] = mk("uflow",    1,  1, 8'h30, 1, 8'h77, 8'h00, 0, 8'h00, 8'h00, 1, 0, 1);

    rst = 1'b1;
    cmd_valid = 0; cmd_wr = 0; cmd_len = 0; cmd_addr = 0;
    tx_valid = 0; tx_data = 0; rx_ready = 0;
    wdat_req = 0; rdat_vld = 0; rdat = 0; trans_over = 0;
    tick(); tick();
    check_reset_outputs("reset");
    rst = 1'b0;
    tick();

    foreach (tbl[i]) begin
      do_cmd(tbl[i]);
      if (!tbl[i].wr && !tbl[i].rej) drain_rx(tbl[i].nrd);
    end
    check("tx_empty_after_table", tx_ready, 1);

    // reset in the middle of a write frame
    push_tx(8'h99);
    cmd_valid = 1'b1; cmd_wr = 1'b1; cmd_len = 8'd1; cmd_addr = 8'h12;
    tick();
    cmd_valid = 1'b0;
    tick(); tick();
    wdat_req = 1'b1;
    tick();
    wdat_req = 1'b0;
    check("midframe_wdat_addr", wdat, 8'h12);
    check("midframe_busy", busy, 1);
    rst = 1'b1;
    #1;
    check_reset_outputs("rst_busy");
    tick();
    rst = 1'b0;
    tx_model.delete();
    tick();
    do_cmd(mk("post_rst_wr1", 1, 1, 8'hC4, 1, 8'hE7, 8'h00, 0, 8'h00, 8'h00, 0, 0, 0));

    // full-depth read held in the RX FIFO, second read must be refused
    rx_ready = 1'b0;
    do_cmd(mk("rd16", 0, 16, 8'h80, 0, 8'h00, 8'h00, 16, 8'h03, 8'h07, 0, 0, 0));
    do_cmd(mk("rd_nofree", 0, 1, 8'h81, 0, 8'h00, 8'h00, 0, 8'h00, 8'h00, 0, 1, 0));
    drain_rx(16);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
